ysyx_23060025_csr_ctrl: RTL and testbench
=========================================

# ysyx_23060025_csr_ctrl

Multi-cycle CSR instruction sequencer between decode/execute and the CSR register file. It accepts one CSR-class instruction at a time (CSRRW/CSRRS/CSRRC, ECALL, MRET) over a valid/ready handshake. It drives the register file's read/write ports for the read-modify-write or trap sequence, then returns the rd value and any PC redirect to write-back over a second valid/ready handshake.

## Interface
- ECALL_CAUSE, 32'd11: mcause value written on ECALL (environment call from M-mode).
- DATA_WIDTH, 32: datapath width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  sequencer idle; accepts on in_valid & in_ready.
- in_op  in  3  001 CSRRW, 010 CSRRS, 011 CSRRC, 100 ECALL, 101 MRET; all other values are illegal.
- in_csr_addr  in  12  target CSR address.
- in_src  in  32  rs1 value, or zero-extended zimm.
- in_pc  in  32  PC of the instruction.
- csr_raddr  out  12  CSR read address.
- csr_rdata  in  32  combinational read data for csr_raddr.
- csr_waddr  out  12  CSR write address.
- csr_wdata  out  32  CSR write data.
- csr_type_o  out  3  000 no write, 001 write csr_waddr, 011 ECALL write (mcause loaded from csr_mcause_o).
- csr_mcause_o  out  32  cause value for an ECALL write.
- out_valid  out  1  result valid to write-back.
- out_ready  in  1  write-back accepts.
- out_rd_wdata  out  32  value for rd (old CSR value).
- out_redirect  out  1  PC redirect required.
- out_redirect_pc  out  32  redirect target.

## Operation
- State machine states: IDLE, EXEC, TRAP_EPC, TRAP_CAUSE, TRAP_VEC, MRET_RD, DONE.
- Accept: in IDLE, in_ready=1. On in_valid & in_ready, latch op, addr, src and pc. Next state:
  - CSR ops -> EXEC.
  - ECALL -> TRAP_EPC.
  - MRET -> MRET_RD.
  - Illegal op -> DONE with rd=0, redirect=0.
- EXEC:
  - csr_raddr = addr; old = csr_rdata; rd latched = old.
  - CSRRW: wdata = src.
  - CSRRS: wdata = old | src.
  - CSRRC: wdata = old & ~src.
  - csr_waddr = addr. csr_type_o = 001, except CSRRS/CSRRC with src==0, which give 000 (no write).
  - Then DONE, redirect=0.
- TRAP_EPC: waddr=0x341, wdata=pc, type=001 -> TRAP_CAUSE.
- TRAP_CAUSE: waddr=0x342, csr_mcause_o=ECALL_CAUSE, type=011 -> TRAP_VEC.
- TRAP_VEC: raddr=0x305; latch redirect_pc=csr_rdata, redirect=1, rd=0 -> DONE.
- MRET_RD: raddr=0x341; latch redirect_pc=csr_rdata, redirect=1, rd=0 -> DONE.
- DONE:
  - out_valid=1; outputs held stable until out_ready.
  - On out_ready -> IDLE.
  - No new accept while in DONE.
- csr_type_o, csr_waddr, csr_wdata and csr_raddr are combinational from state and latched fields. In IDLE and DONE: type=000, addresses and wdata = 0.
- Arithmetic is bitwise only; no width extension beyond in_src as supplied.

## Timing
- Reset (asynchronous): state=IDLE, all latched fields=0.
  - Outputs: out_valid=0, in_ready=1, out_rd_wdata=0, out_redirect=0, out_redirect_pc=0, csr_type_o=000.
- Reset mid-sequence: csr_type_o drops to 000 immediately. No partial trap is resumed; e.g. mepc written but mcause not is acceptable and is not retried.
- Latency from accept edge to out_valid high:
  - CSR op: 2 cycles.
  - ECALL: 4 cycles.
  - MRET: 2 cycles.
  - Illegal: 1 cycle.
- CSR writes land on the clock edge that ends the writing state. A read in a later state sees the new value.
- Back-to-back: minimum 1 IDLE cycle between instructions. in_ready rises the cycle after the out handshake.
- out_ready held low: the sequencer stalls indefinitely in DONE with outputs stable.
- out_ready already high on entry to DONE: out_valid is high for exactly 1 cycle.

## Test plan
- CSRRW, addr 0x305, src 0x8000_0100, mtvec initially 0x0 -> one write cycle (type 001, waddr 0x305, wdata 0x8000_0100); out_rd_wdata=0x0, out_valid 2 cycles after accept.
- CSRRS on mtvec=0x0000_00F0 with src 0x0F -> wdata 0x0000_00FF, rd=0x0000_00F0. Repeat with src 0 -> type stays 000, rd=0x0000_00FF.
- CSRRC on mcause=0xFF with src 0x0F -> wdata 0xF0, rd=0xFF.
- ECALL at pc 0x8000_0040, mtvec=0x8000_1000 -> mepc write 0x8000_0040, then type 011 with csr_mcause_o=11; out_redirect=1, redirect_pc=0x8000_1000, out_valid 4 cycles after accept.
- MRET with mepc=0x8000_0044, out_ready held low 5 cycles -> redirect_pc=0x8000_0044 held stable, in_ready=0 throughout; in_ready=1 the cycle after out_ready.
- Reset asserted during TRAP_CAUSE -> csr_type_o=000 immediately, out_valid=0, in_ready=1 after release; mcause unchanged.

Source files
------------

// File: rtl/ysyx_23060025_csr_ctrl.sv
// Multi-cycle CSR sequencer: runs the read-modify-write for CSRRW/CSRRS/CSRRC,
// the three-step ECALL trap entry and the MRET mepc read, then hands rd/redirect to write-back.
module ysyx_23060025_csr_ctrl #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] ECALL_CAUSE = 32'd11
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [11:0]           in_csr_addr,
  input  logic [DATA_WIDTH-1:0] in_src,
  input  logic [DATA_WIDTH-1:0] in_pc,
  output logic [11:0]           csr_raddr,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic [11:0]           csr_waddr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic [2:0]            csr_type_o,
  output logic [DATA_WIDTH-1:0] csr_mcause_o,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rd_wdata,
  output logic                  out_redirect,
  output logic [DATA_WIDTH-1:0] out_redirect_pc
);

  localparam logic [2:0] OP_CSRRW = 3'b001;
  localparam logic [2:0] OP_CSRRS = 3'b010;
  localparam logic [2:0] OP_CSRRC = 3'b011;
  localparam logic [2:0] OP_ECALL = 3'b100;
  localparam logic [2:0] OP_MRET  = 3'b101;

  localparam logic [11:0] ADDR_MTVEC  = 12'h305;
  localparam logic [11:0] ADDR_MEPC   = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE = 12'h342;

  localparam logic [2:0] TYPE_NONE  = 3'b000;
  localparam logic [2:0] TYPE_WRITE = 3'b001;
  localparam logic [2:0] TYPE_ECALL = 3'b011;

  typedef enum logic [2:0] {
    IDLE, EXEC, TRAP_EPC, TRAP_CAUSE, TRAP_VEC, MRET_RD, DONE
  } state_t;

  state_t                state;
  logic [2:0]            op_q;
  logic [11:0]           addr_q;
  logic [DATA_WIDTH-1:0] src_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  redirect_q;
  logic [DATA_WIDTH-1:0] redirect_pc_q;

  function automatic logic [DATA_WIDTH-1:0] rmw_data(
    input logic [2:0] op, input logic [DATA_WIDTH-1:0] old, input logic [DATA_WIDTH-1:0] src
  );
    case (op)
      OP_CSRRS: rmw_data = old | src;
      OP_CSRRC: rmw_data = old & ~src;
      default:  rmw_data = src;
    endcase
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      op_q          <= '0;
      addr_q        <= '0;
      src_q         <= '0;
      pc_q          <= '0;
      rd_q          <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q          <= in_op;
            addr_q        <= in_csr_addr;
            src_q         <= in_src;
            pc_q          <= in_pc;
            rd_q          <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            case (in_op)
              OP_CSRRW, OP_CSRRS, OP_CSRRC: state <= EXEC;
              OP_ECALL:                     state <= TRAP_EPC;
              OP_MRET:                      state <= MRET_RD;
              default:                      state <= DONE;
            endcase
          end
        end
        EXEC: begin
          rd_q  <= csr_rdata;
          state <= DONE;
        end
        TRAP_EPC:   state <= TRAP_CAUSE;
        TRAP_CAUSE: state <= TRAP_VEC;
        TRAP_VEC, MRET_RD: begin
          redirect_pc_q <= csr_rdata;
          redirect_q    <= 1'b1;
          rd_q          <= '0;
          state         <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready        = (state == IDLE);
  assign out_valid       = (state == DONE);
  assign out_rd_wdata    = rd_q;
  assign out_redirect    = redirect_q;
  assign out_redirect_pc = redirect_pc_q;

  // Register-file port drive; idle/done states leave every port at zero.
  always_comb begin
    csr_raddr    = '0;
    csr_waddr    = '0;
    csr_wdata    = '0;
    csr_type_o   = TYPE_NONE;
    csr_mcause_o = '0;
    case (state)
      EXEC: begin
        csr_raddr  = addr_q;
        csr_waddr  = addr_q;
        csr_wdata  = rmw_data(op_q, csr_rdata, src_q);
        csr_type_o = (op_q != OP_CSRRW && src_q == '0) ? TYPE_NONE : TYPE_WRITE;
      end
      TRAP_EPC: begin
        csr_waddr  = ADDR_MEPC;
        csr_wdata  = pc_q;
        csr_type_o = TYPE_WRITE;
      end
      TRAP_CAUSE: begin
        csr_waddr    = ADDR_MCAUSE;
        csr_mcause_o = ECALL_CAUSE;
        csr_type_o   = TYPE_ECALL;
      end
      TRAP_VEC: csr_raddr = ADDR_MTVEC;
      MRET_RD:  csr_raddr = ADDR_MEPC;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060025_csr_ctrl.sv
// Scoreboard bench for the CSR sequencer: a CSR array model answers the register-file
// ports, a reference model predicts each result, and a monitor checks every write-back handshake.
module tb_ysyx_23060025_csr_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [11:0] in_csr_addr = '0;
  logic [31:0] in_src = '0;
  logic [31:0] in_pc = '0;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [2:0]  csr_type_o;
  logic [31:0] csr_mcause_o;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rd_wdata;
  logic        out_redirect;
  logic [31:0] out_redirect_pc;

  ysyx_23060025_csr_ctrl dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_csr_addr(in_csr_addr), .in_src(in_src), .in_pc(in_pc),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .csr_type_o(csr_type_o), .csr_mcause_o(csr_mcause_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd_wdata(out_rd_wdata),
    .out_redirect(out_redirect), .out_redirect_pc(out_redirect_pc)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // CSR register file seen by the DUT
  logic [31:0] csr_mem [0:4095];
  logic        clear_mem = 1'b1;
  assign csr_rdata = csr_mem[csr_raddr];
  always @(posedge clock) begin
    if (clear_mem) begin
      for (int i = 0; i < 4096; i++) csr_mem[i] <= '0;
    end else if (!reset) begin
      if (csr_type_o == 3'b001) csr_mem[csr_waddr] <= csr_wdata;
      else if (csr_type_o == 3'b011) csr_mem[csr_waddr] <= csr_mcause_o;
    end
  end

  logic force_low = 1'b0;
  always @(posedge clock) begin
    #1;
    out_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  typedef struct {
    logic [31:0] rd;
    logic        redir;
    logic [31:0] rpc;
    int          lat;
    int          writes;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] ref_csr [0:4095];
  logic [11:0] addr_set [0:4] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic abort_run(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", nm, $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Monitor: pops one expectation per write-back handshake
  logic        mon_en = 1'b0;
  logic        busy = 1'b0;
  logic        seen = 1'b0;
  logic        ready_next = 1'b0;
  int          acc_cyc = 0;
  int          wcnt = 0;
  int          lat = 0;
  int          done_cnt = 0;
  logic [31:0] cap_rd, cap_rpc;
  logic        cap_redir;

  always @(negedge clock) begin
    if (mon_en) begin
      if (ready_next) begin
        chk("in_ready_after_handshake", 32'(in_ready), 32'd1);
        ready_next = 1'b0;
      end
      if (in_valid && in_ready) begin
        busy = 1'b1; seen = 1'b0; wcnt = 0; acc_cyc = cyc;
      end else if (busy) begin
        if (csr_type_o != 3'b000) wcnt++;
        if (out_valid) begin
          if (!seen) begin
            seen = 1'b1;
            lat = cyc - acc_cyc;
            cap_rd = out_rd_wdata; cap_rpc = out_redirect_pc; cap_redir = out_redirect;
            chk("in_ready_low_in_done", 32'(in_ready), 32'd0);
          end
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_result", 32'(out_valid), 32'd0);
            end else begin
              exp_t e;
              e = exp_q.pop_front();
              chk("rd_wdata", out_rd_wdata, e.rd);
              chk("redirect", 32'(out_redirect), 32'(e.redir));
              chk("redirect_pc", out_redirect_pc, e.rpc);
              chk("latency", 32'(lat), 32'(e.lat));
              chk("write_cycles", 32'(wcnt), 32'(e.writes));
              chk("stable_rd", out_rd_wdata, cap_rd);
              chk("stable_rpc", out_redirect_pc, cap_rpc);
              chk("stable_redirect", 32'(out_redirect), 32'(cap_redir));
              for (int i = 0; i < 5; i++) chk("csr_state", csr_mem[addr_set[i]], ref_csr[addr_set[i]]);
            end
            busy = 1'b0; ready_next = 1'b1; done_cnt++;
          end
        end
      end else begin
        chk("spurious_out_valid", 32'(out_valid), 32'd0);
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [11:0] a, input logic [31:0] s, input logic [31:0] p);
    int n = 0;
    @(posedge clock); #1;
    while (!in_ready) begin
      n++;
      if (n > 200) abort_run("in_ready_wait");
      @(posedge clock); #1;
    end
    in_op = op; in_csr_addr = a; in_src = s; in_pc = p; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target) begin
      n++;
      if (n > 200) abort_run("out_handshake_wait");
      @(posedge clock);
    end
  endtask

  // Reference model: predicts the result and updates the model CSR array
  task automatic predict(input logic [2:0] op, input logic [11:0] a, input logic [31:0] s, input logic [31:0] p);
    exp_t e;
    logic [31:0] old;
    old = ref_csr[a];
    e.rd = 32'd0; e.redir = 1'b0; e.rpc = 32'd0; e.lat = 1; e.writes = 0;
    case (op)
      3'd1: begin e.rd = old; e.lat = 2; e.writes = 1; ref_csr[a] = s; end
      3'd2: begin e.rd = old; e.lat = 2; if (s != 0) begin e.writes = 1; ref_csr[a] = old | s; end end
      3'd3: begin e.rd = old; e.lat = 2; if (s != 0) begin e.writes = 1; ref_csr[a] = old & ~s; end end
      3'd4: begin
        ref_csr[12'h341] = p; ref_csr[12'h342] = 32'd11;
        e.redir = 1'b1; e.rpc = ref_csr[12'h305]; e.lat = 4; e.writes = 2;
      end
      3'd5: begin e.redir = 1'b1; e.rpc = ref_csr[12'h341]; e.lat = 2; end
      default: ;
    endcase
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] op, input logic [11:0] a, input logic [31:0] s, input logic [31:0] p);
    int target;
    target = done_cnt + 1;
    predict(op, a, s, p);
    send(op, a, s, p);
    wait_done(target);
  endtask

  initial begin
    int target;
    logic [31:0] saved_cause;
    for (int i = 0; i < 4096; i++) ref_csr[i] = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_rd_wdata", out_rd_wdata, 32'd0);
    chk("rst_redirect", 32'(out_redirect), 32'd0);
    chk("rst_redirect_pc", out_redirect_pc, 32'd0);
    chk("rst_csr_type", 32'(csr_type_o), 32'd0);
    clear_mem = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    mon_en = 1'b1;

    issue(3'd1, 12'h305, 32'h8000_0100, 32'h8000_0000);
    issue(3'd1, 12'h305, 32'h0000_00F0, 32'h8000_0004);
    issue(3'd2, 12'h305, 32'h0000_000F, 32'h8000_0008);
    issue(3'd2, 12'h305, 32'h0000_0000, 32'h8000_000C);
    issue(3'd1, 12'h342, 32'h0000_00FF, 32'h8000_0010);
    issue(3'd3, 12'h342, 32'h0000_000F, 32'h8000_0014);
    issue(3'd1, 12'h305, 32'h8000_1000, 32'h8000_0018);
    issue(3'd4, 12'h000, 32'h0000_0000, 32'h8000_0040);
    issue(3'd0, 12'h300, 32'h1234_5678, 32'h8000_0044);
    issue(3'd7, 12'h300, 32'h1234_5678, 32'h8000_0048);

    // MRET with write-back stalled
    issue(3'd1, 12'h341, 32'h8000_0044, 32'h8000_004C);
    force_low = 1'b1;
    target = done_cnt + 1;
    predict(3'd5, 12'h000, 32'd0, 32'h8000_0050);
    send(3'd5, 12'h000, 32'd0, 32'h8000_0050);
    repeat (6) @(posedge clock);
    #1;
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_redirect_pc", out_redirect_pc, 32'h8000_0044);
    force_low = 1'b0;
    wait_done(target);

    for (int t = 0; t < 300; t++) begin
      logic [2:0]  op;
      logic [31:0] s;
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1: op = 3'd1;
        2, 3: op = 3'd2;
        4, 5: op = 3'd3;
        6:    op = 3'd4;
        7:    op = 3'd5;
        8:    op = 3'd0;
        default: op = 3'($urandom_range(6, 7));
      endcase
      s = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      issue(op, addr_set[$urandom_range(0, 4)], s, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
    end

    // Reset while the trap sequence sits in its mcause step
    @(posedge clock);
    while (!in_ready) @(posedge clock);
    mon_en = 1'b0;
    saved_cause = ref_csr[12'h342];
    send(3'd4, 12'h000, 32'd0, 32'h8000_0080);
    @(posedge clock); #1;
    chk("trap_cause_type", 32'(csr_type_o), 32'd3);
    reset = 1'b1;
    #1;
    chk("midrst_csr_type", 32'(csr_type_o), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_mcause_kept", csr_mem[12'h342], saved_cause);
    chk("midrst_mepc_written", csr_mem[12'h341], 32'h8000_0080);
    chk("midrst_in_ready_after", 32'(in_ready), 32'd1);
    ref_csr[12'h341] = 32'h8000_0080;
    mon_en = 1'b1;
    issue(3'd5, 12'h000, 32'd0, 32'h8000_0084);
    issue(3'd1, 12'h340, 32'hCAFE_F00D, 32'h8000_0088);

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
